// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single register-file write port between two writeback
//   requesters: A (ALU result path) and B (memory-load path). Each requester
//   feeds a small FIFO through a valid/ready handshake. A round-robin arbiter
//   drains the FIFO heads into a registered write port. Two hazard flags report
//   whether a monitored read select names a register that still has a write in
//   flight, either queued or sitting on the write port this cycle.
//
// Ports
//   clk                     clock, all state updates on posedge
//   rst                     synchronous active-high reset
//   a_valid/a_ready         requester A handshake
//   a_addr/a_data           requester A destination register and value
//   b_valid/b_ready         requester B handshake
//   b_addr/b_data           requester B destination register and value
//   write_data              registered write data to the register file
//   write_address           registered write address to the register file
//   RegWrite                registered write enable to the register file
//   read_sel_1/read_sel_2   monitored register file read selects
//   hazard_1/hazard_2       pending-write flags for the read selects (comb.)
// ----------------------------------------------------------------------------

// Per-requester FIFO with per-entry valid bits so pending destination
// registers can be compared against the read selects.
//   clk, rst                  clock and synchronous reset
//   i_valid/o_ready           push handshake
//   i_addr/i_data             push payload
//   i_pop                     pop the head on this edge (only when non-empty)
//   o_nonempty                head entry is valid
//   o_head_addr/o_head_data   head entry payload
//   i_sel_1/i_sel_2           read selects to compare against queued entries
//   o_match_1/o_match_2       a valid queued entry targets the read select
module regfile_write_arbiter_fifo #(
  parameter int data_width = 32,
  parameter int addr_width = 5,
  parameter int fifo_depth = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [addr_width-1:0] i_addr,
  input  logic [data_width-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_nonempty,
  output logic [addr_width-1:0] o_head_addr,
  output logic [data_width-1:0] o_head_data,
  input  logic [addr_width-1:0] i_sel_1,
  input  logic [addr_width-1:0] i_sel_2,
  output logic                  o_match_1,
  output logic                  o_match_2
);

  localparam int CNT_W = $clog2(fifo_depth + 1);
  localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(fifo_depth);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(fifo_depth - 1);

  logic [addr_width-1:0] r_addr [fifo_depth];
  logic [data_width-1:0] r_data [fifo_depth];
  logic [fifo_depth-1:0] r_vld;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_push;
  logic w_match_1;
  logic w_match_2;

  // Pointers wrap at fifo_depth, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Readiness depends only on the current count; no pop bypass into a full FIFO.
  assign o_ready     = ~rst & (r_count < DEPTH_C);
  assign w_push      = i_valid & o_ready;
  assign o_nonempty  = (r_count != '0);
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_match_1   = w_match_1;
  assign o_match_2   = w_match_2;

  // Storage, valid bits, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // A push never targets the head slot while it is being popped: a push
      // needs a free slot, so the write pointer differs from a non-empty head.
      if (i_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= ptr_next(r_rd_ptr);
      end
      if (w_push) begin
        r_addr[r_wr_ptr] <= i_addr;
        r_data[r_wr_ptr] <= i_data;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= ptr_next(r_wr_ptr);
      end
      case ({w_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Compare every valid queued destination against both read selects.
  always_comb begin
    w_match_1 = 1'b0;
    w_match_2 = 1'b0;
    for (int i = 0; i < fifo_depth; i++) begin
      w_match_1 = w_match_1 | (r_vld[i] & (r_addr[i] == i_sel_1));
      w_match_2 = w_match_2 | (r_vld[i] & (r_addr[i] == i_sel_2));
    end
  end

endmodule

module regfile_write_arbiter #(
  parameter int data_width = 32,
  parameter int addr_width = 5,
  parameter int fifo_depth = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [addr_width-1:0] a_addr,
  input  logic [data_width-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [addr_width-1:0] b_addr,
  input  logic [data_width-1:0] b_data,
  output logic [data_width-1:0] write_data,
  output logic [addr_width-1:0] write_address,
  output logic                  RegWrite,
  input  logic [addr_width-1:0] read_sel_1,
  input  logic [addr_width-1:0] read_sel_2,
  output logic                  hazard_1,
  output logic                  hazard_2
);

  logic                  w_a_nonempty;
  logic                  w_b_nonempty;
  logic [addr_width-1:0] w_a_head_addr;
  logic [addr_width-1:0] w_b_head_addr;
  logic [data_width-1:0] w_a_head_data;
  logic [data_width-1:0] w_b_head_data;
  logic                  w_a_match_1;
  logic                  w_a_match_2;
  logic                  w_b_match_1;
  logic                  w_b_match_2;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic [addr_width-1:0] w_sel_addr;
  logic [data_width-1:0] w_sel_data;
  logic                  w_port_match_1;
  logic                  w_port_match_2;

  logic                  r_last_grant_b;
  logic                  r_regwrite;
  logic [addr_width-1:0] r_waddr;
  logic [data_width-1:0] r_wdata;

  regfile_write_arbiter_fifo #(
    .data_width (data_width),
    .addr_width (addr_width),
    .fifo_depth (fifo_depth)
  ) u_fifo_a (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (a_valid),
    .o_ready     (a_ready),
    .i_addr      (a_addr),
    .i_data      (a_data),
    .i_pop       (w_grant_a),
    .o_nonempty  (w_a_nonempty),
    .o_head_addr (w_a_head_addr),
    .o_head_data (w_a_head_data),
    .i_sel_1     (read_sel_1),
    .i_sel_2     (read_sel_2),
    .o_match_1   (w_a_match_1),
    .o_match_2   (w_a_match_2)
  );

  regfile_write_arbiter_fifo #(
    .data_width (data_width),
    .addr_width (addr_width),
    .fifo_depth (fifo_depth)
  ) u_fifo_b (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (b_valid),
    .o_ready     (b_ready),
    .i_addr      (b_addr),
    .i_data      (b_data),
    .i_pop       (w_grant_b),
    .o_nonempty  (w_b_nonempty),
    .o_head_addr (w_b_head_addr),
    .o_head_data (w_b_head_data),
    .i_sel_1     (read_sel_1),
    .i_sel_2     (read_sel_2),
    .o_match_1   (w_b_match_1),
    .o_match_2   (w_b_match_2)
  );

  // Round robin: a lone non-empty FIFO wins; on a tie the one not granted last wins.
  assign w_grant_a = w_a_nonempty & (~w_b_nonempty | r_last_grant_b);
  assign w_grant_b = w_b_nonempty & (~w_a_nonempty | ~r_last_grant_b);

  // Select the payload of the granted head.
  always_comb begin
    w_sel_addr = w_a_head_addr;
    w_sel_data = w_a_head_data;
    if (w_grant_b) begin
      w_sel_addr = w_b_head_addr;
      w_sel_data = w_b_head_data;
    end else begin
      w_sel_addr = w_a_head_addr;
      w_sel_data = w_a_head_data;
    end
  end

  // Registered write port and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant_b <= 1'b1;
      r_regwrite     <= 1'b0;
      r_waddr        <= '0;
      r_wdata        <= '0;
    end else if (w_grant_a | w_grant_b) begin
      r_last_grant_b <= w_grant_b;
      // Register 0 is hardwired zero: the entry is consumed but never written.
      r_regwrite     <= (w_sel_addr != '0);
      r_waddr        <= w_sel_addr;
      r_wdata        <= w_sel_data;
    end else begin
      r_regwrite     <= 1'b0;
    end
  end

  assign write_data    = r_wdata;
  assign write_address = r_waddr;
  assign RegWrite      = r_regwrite;

  // The write on the port this cycle lands at the next edge, so it still counts.
  assign w_port_match_1 = r_regwrite & (r_waddr == read_sel_1);
  assign w_port_match_2 = r_regwrite & (r_waddr == read_sel_2);

  assign hazard_1 = (read_sel_1 != '0) & (w_a_match_1 | w_b_match_1 | w_port_match_1);
  assign hazard_2 = (read_sel_2 != '0) & (w_a_match_2 | w_b_match_2 | w_port_match_2);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic [DW-1:0] write_data;
  logic [AW-1:0] write_address;
  logic          RegWrite;
  logic [AW-1:0] read_sel_1, read_sel_2;
  logic          hazard_1, hazard_2;

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter #(
    .data_width (DW),
    .addr_width (AW),
    .fifo_depth (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_addr        (a_addr),
    .a_data        (a_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .write_data    (write_data),
    .write_address (write_address),
    .RegWrite      (RegWrite),
    .read_sel_1    (read_sel_1),
    .read_sel_2    (read_sel_2),
    .hazard_1      (hazard_1),
    .hazard_2      (hazard_2)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  ent_t          qa[$];
  ent_t          qb[$];
  logic          m_last_b = 1'b1;
  logic          m_rw     = 1'b0;
  logic [AW-1:0] m_waddr  = '0;
  logic [DW-1:0] m_wdata  = '0;
  logic          m_live   = 1'b0;

  always @(posedge clk) begin : model
    bit   ga, gb, pa, pb;
    ent_t h;
    if (rst) begin
      qa.delete();
      qb.delete();
      m_last_b <= 1'b1;
      m_rw     <= 1'b0;
      m_waddr  <= '0;
      m_wdata  <= '0;
      m_live   <= 1'b1;
    end else begin
      pa = a_valid && (qa.size() < DEPTH);
      pb = b_valid && (qb.size() < DEPTH);
      ga = (qa.size() > 0) && ((qb.size() == 0) || m_last_b);
      gb = (qb.size() > 0) && !ga;
      h  = '0;
      if (ga) begin
        h = qa.pop_front();
        m_last_b <= 1'b0;
      end else if (gb) begin
        h = qb.pop_front();
        m_last_b <= 1'b1;
      end
      if (ga || gb) begin
        m_rw    <= (h.addr != '0);
        m_waddr <= h.addr;
        m_wdata <= h.data;
      end else begin
        m_rw <= 1'b0;
      end
      if (pa) qa.push_back({a_addr, a_data});
      if (pb) qb.push_back({b_addr, b_data});
    end
  end

  function automatic bit exp_hazard(input logic [AW-1:0] sel);
    bit hit;
    hit = m_rw && (m_waddr == sel);
    foreach (qa[i]) if (qa[i].addr == sel) hit = 1'b1;
    foreach (qb[i]) if (qb[i].addr == sel) hit = 1'b1;
    return (sel != '0) && hit;
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_live) begin
      cmp("a_ready",       64'(a_ready),       64'(!rst && (qa.size() < DEPTH)));
      cmp("b_ready",       64'(b_ready),       64'(!rst && (qb.size() < DEPTH)));
      cmp("RegWrite",      64'(RegWrite),      64'(m_rw));
      cmp("write_address", 64'(write_address), 64'(m_waddr));
      cmp("write_data",    64'(write_data),    64'(m_wdata));
      cmp("hazard_1",      64'(hazard_1),      64'(exp_hazard(read_sel_1)));
      cmp("hazard_2",      64'(hazard_2),      64'(exp_hazard(read_sel_2)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0009;
    b_valid = 1'b0; b_addr = '0;   b_data = '0;
    read_sel_1 = '0; read_sel_2 = '0;

    // Reset held two cycles with A offering.
    tick(); at_neg();
    cmp("lit_rst_a_ready", 64'(a_ready), 64'd0);
    cmp("lit_rst_regwrite", 64'(RegWrite), 64'd0);
    tick(); rst = 1'b0;
    at_neg();
    cmp("lit_post_rst_ready", 64'(a_ready), 64'd1);
    cmp("lit_post_rst_addr", 64'(write_address), 64'd0);
    tick(); a_valid = 1'b0;
    at_neg();
    cmp("lit_first_e0_rw", 64'(RegWrite), 64'd0);
    tick(); at_neg();
    cmp("lit_first_rw", 64'(RegWrite), 64'd1);
    cmp("lit_first_addr", 64'(write_address), 64'd9);

    // Single write with hazard watch.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF; read_sel_1 = 5'd5;
    tick(); a_valid = 1'b0;
    at_neg();
    cmp("lit_single_haz_e0", 64'(hazard_1), 64'd1);
    tick(); at_neg();
    cmp("lit_single_rw", 64'(RegWrite), 64'd1);
    cmp("lit_single_addr", 64'(write_address), 64'd5);
    cmp("lit_single_data", 64'(write_data), 64'hDEAD_BEEF);
    tick(); at_neg();
    cmp("lit_single_rw_off", 64'(RegWrite), 64'd0);
    cmp("lit_single_haz_off", 64'(hazard_1), 64'd0);
    read_sel_1 = '0;

    // Contention after reset: A first, then B; next tie goes to A again.
    rst = 1'b1; tick(); rst = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
    tick(); a_valid = 1'b0; b_valid = 1'b0;
    tick(); at_neg();
    cmp("lit_cont_first", 64'(write_data), 64'h11);
    tick(); at_neg();
    cmp("lit_cont_second", 64'(write_data), 64'h22);
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h44;
    tick(); a_valid = 1'b0; b_valid = 1'b0;
    tick(); at_neg();
    cmp("lit_cont2_first", 64'(write_address), 64'd6);
    tick(); at_neg();
    cmp("lit_cont2_second", 64'(write_address), 64'd8);

    // Both streaming: each FIFO drains every other cycle and hits full.
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA0;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hB0;
    tick(); tick(); at_neg();
    cmp("lit_full_b_ready", 64'(b_ready), 64'd0);
    cmp("lit_full_a_ready1", 64'(a_ready), 64'd1);
    tick(); at_neg();
    cmp("lit_full_a_ready", 64'(a_ready), 64'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (6) tick();

    // Register 0 is consumed silently; hazard window of a real write.
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFF;
    tick(); a_valid = 1'b0;
    tick(); at_neg();
    cmp("lit_reg0_rw", 64'(RegWrite), 64'd0);
    read_sel_1 = 5'd7; read_sel_2 = 5'd0;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
    tick(); a_valid = 1'b0;
    at_neg();
    cmp("lit_haz_push", 64'(hazard_1), 64'd1);
    cmp("lit_haz2_zero", 64'(hazard_2), 64'd0);
    tick(); at_neg();
    cmp("lit_haz_port", 64'(hazard_1), 64'd1);
    tick(); at_neg();
    cmp("lit_haz_clear", 64'(hazard_1), 64'd0);

    // Reset mid-flight discards queued writes.
    read_sel_1 = 5'd12; read_sel_2 = 5'd13;
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC0;
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hD0;
    tick(); tick();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    tick(); rst = 1'b0;
    at_neg();
    cmp("lit_mid_rst_rw", 64'(RegWrite), 64'd0);
    cmp("lit_mid_rst_h1", 64'(hazard_1), 64'd0);
    cmp("lit_mid_rst_h2", 64'(hazard_2), 64'd0);
    repeat (4) begin
      tick(); at_neg();
      cmp("lit_mid_rst_quiet", 64'(RegWrite), 64'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst        = ($urandom_range(0, 127) == 0);
      a_valid    = ($urandom_range(0, 3) != 0);
      b_valid    = ($urandom_range(0, 3) != 0);
      a_addr     = AW'($urandom_range(0, 7));
      b_addr     = AW'($urandom_range(0, 7));
      a_data     = $urandom;
      b_data     = $urandom;
      read_sel_1 = AW'($urandom_range(0, 7));
      read_sel_2 = AW'($urandom_range(0, 7));
    end
    tick();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (8) tick();
    at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
